// File: rtl/claim_rasterizer.sv
// claim_rasterizer
//
// Walks a fabric claim rectangle (left, top, w, h) cell by cell and streams
// every covered (x, y) coordinate tagged with the claim id, in row-major order
// with x innermost.
//
// Handshakes (both ports): a transfer happens on a rising clock edge where
// valid && ready are both 1. A producer holds valid and its payload stable
// until that transfer. in_ready decodes the state register. All other outputs
// are registered.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   claim offer / acceptance (ready only in IDLE)
//   in_left, in_top       claim origin
//   in_w, in_h            claim width and height (zero area emits nothing)
//   in_id                 claim id
//   out_valid / out_ready cell beat handshake
//   out_x, out_y          cell coordinate
//   out_id                id of the claim being scanned
//   out_last              beat is the claim's final cell
//   done                  one-cycle pulse after the claim scan finishes
//   busy                  state is SCAN (FSM state visibility)
//
// Optional feature macro: CLAIM_RASTER_CLIP_EN
//   undefined: coordinates wrap modulo 2^W and all w*h cells are emitted.
//   defined:   cells with x or y >= FABRIC_SIZE are suppressed; offsets still
//              advance through them, one per cycle, without a handshake.

module claim_rasterizer #(
  parameter int W           = 10,
  parameter int ID_W        = 11,
  parameter int FABRIC_SIZE = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_left,
  input  logic [W-1:0]    in_top,
  input  logic [W-1:0]    in_w,
  input  logic [W-1:0]    in_h,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_x,
  output logic [W-1:0]    out_y,
  output logic [ID_W-1:0] out_id,
  output logic            out_last,
  output logic            done,
  output logic            busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [W-1:0] ONE  = W'(1);
  localparam logic [W-1:0] ZERO = '0;

  state_t state, state_next;

  // Latched claim and scan offsets.
  logic [W-1:0]    left_q, top_q, w_q, h_q;
  logic [ID_W-1:0] id_q;
  logic [W-1:0]    ox, oy;

  // Control decode.
  logic accept, x_end, at_end, step;
  logic load, advance, finish, zero_done;

  // Candidate cell: the cell that will be presented next cycle, either the
  // first cell of a newly loaded claim or the successor of the current one.
  logic [W-1:0]    c_left, c_top, c_w, c_h, c_ox, c_oy;
  logic [W-1:0]    c_x, c_y;
  logic [ID_W-1:0] c_id;
  logic            c_last, c_ok;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  // Termination compares offsets against size-1, so no left+w sum is needed.
  assign x_end  = (ox == w_q - ONE);
  assign at_end = x_end && (oy == h_q - ONE);

  // A scan cycle retires the current cell when the beat is taken, or at once
  // when the cell was suppressed (out_valid low during SCAN).
  assign step = (state == SCAN) && (out_ready || !out_valid);

  always_comb begin
    state_next = state;
    load       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    zero_done  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_w == ZERO || in_h == ZERO) begin
            zero_done = 1'b1;
          end else begin
            load       = 1'b1;
            state_next = SCAN;
          end
        end
      end
      SCAN: begin
        if (step) begin
          if (at_end) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    c_left = load ? in_left : left_q;
    c_top  = load ? in_top  : top_q;
    c_w    = load ? in_w    : w_q;
    c_h    = load ? in_h    : h_q;
    c_id   = load ? in_id   : id_q;
    c_ox   = load ? ZERO : (x_end ? ZERO : ox + ONE);
    c_oy   = load ? ZERO : (x_end ? oy + ONE : oy);
    c_last = (c_ox == c_w - ONE) && (c_oy == c_h - ONE);
  end

`ifdef CLAIM_RASTER_CLIP_EN
  localparam logic [W:0] FAB = (W+1)'(FABRIC_SIZE);
  logic [W:0] sum_x, sum_y;

  // Full-width sums so a cell past the fabric edge is never aliased back in.
  always_comb begin
    sum_x = {1'b0, c_left} + {1'b0, c_ox};
    sum_y = {1'b0, c_top}  + {1'b0, c_oy};
    c_x   = sum_x[W-1:0];
    c_y   = sum_y[W-1:0];
    c_ok  = (sum_x < FAB) && (sum_y < FAB);
  end
`else
  always_comb begin
    c_x  = c_left + c_ox;
    c_y  = c_top  + c_oy;
    c_ok = 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      left_q    <= '0;
      top_q     <= '0;
      w_q       <= '0;
      h_q       <= '0;
      id_q      <= '0;
      ox        <= '0;
      oy        <= '0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_next;
      done  <= finish || zero_done;
      busy  <= (state_next == SCAN);
      if (load) begin
        left_q <= in_left;
        top_q  <= in_top;
        w_q    <= in_w;
        h_q    <= in_h;
        id_q   <= in_id;
      end
      if (load || advance) begin
        ox        <= c_ox;
        oy        <= c_oy;
        out_x     <= c_x;
        out_y     <= c_y;
        out_id    <= c_id;
        out_valid <= c_ok;
        // A suppressed final cell carries no last marker.
        out_last  <= c_last && c_ok;
      end else if (finish) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_claim_rasterizer.sv
// Testbench for claim_rasterizer: directed claims with hand-computed beat
// lists, cycle-exact latency checks, backpressure, reset mid-scan and
// back-to-back claims. Expectations for the edge-of-fabric case follow the
// CLAIM_RASTER_CLIP_EN macro.

module tb_claim_rasterizer;

  localparam int W    = 10;
  localparam int ID_W = 11;
  localparam int BW   = 2 * W + ID_W + 1;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_left, in_top, in_w, in_h;
  logic [ID_W-1:0] in_id;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_x, out_y;
  logic [ID_W-1:0] out_id;
  logic            out_last;
  logic            done;
  logic            busy;

  claim_rasterizer #(.W(W), .ID_W(ID_W), .FABRIC_SIZE(1000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_left   (in_left),
    .in_top    (in_top),
    .in_w      (in_w),
    .in_h      (in_h),
    .in_id     (in_id),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_id    (out_id),
    .out_last  (out_last),
    .done      (done),
    .busy      (busy)
  );

  // Scoreboard
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  logic [BW-1:0] held_q[$];
  int vec  = 0;
  int errs = 0;
  int acc_cyc, done_cyc, first_cyc, last_cyc;
  int bp_at  = -1;
  int bp_len = 0;

  function automatic logic [BW-1:0] beat(input int x, input int y, input int id, input bit last);
    logic [W-1:0]    bx;
    logic [W-1:0]    by;
    logic [ID_W-1:0] bid;
    bx  = W'(x);
    by  = W'(y);
    bid = ID_W'(id);
    return {bx, by, bid, last};
  endfunction

  function automatic logic [BW-1:0] cur_beat();
    return {out_x, out_y, out_id, out_last};
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_claim(input int id, input int l, input int t, input int w, input int h);
    int n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_id    = ID_W'(id);
    in_left  = W'(l);
    in_top   = W'(t);
    in_w     = W'(w);
    in_h     = W'(h);
    acc_cyc  = cyc;
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: gathers handshaked beats until done (or max_beats), applying the
  // optional stall window described by bp_at / bp_len.
  task automatic collect(input int budget, input int max_beats);
    int stalls = 0;
    got_q.delete();
    held_q.delete();
    done_cyc  = -1;
    first_cyc = -1;
    last_cyc  = -1;
    for (int i = 0; i < budget; i++) begin
      if (bp_len > 0 && got_q.size() == bp_at && stalls < bp_len) begin
        out_ready = 1'b0;
        stalls++;
        if (out_valid) held_q.push_back(cur_beat());
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (first_cyc < 0) first_cyc = cyc;
        got_q.push_back(cur_beat());
        last_cyc = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (max_beats > 0 && got_q.size() == max_beats) break;
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic compare_beats(input string name);
    logic [BW-1:0] g;
    vec++;
    if (got_q.size() !== exp_q.size()) begin
      errs++;
      $display("FAIL %s beat count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = 'x;
      if (i < got_q.size()) g = got_q[i];
      vec++;
      if (g !== exp_q[i]) begin
        errs++;
        $display("FAIL %s beat %0d: got x=%0d y=%0d id=%0d last=%0b expected x=%0d y=%0d id=%0d last=%0b",
                 name, i, g[BW-1 -: W], g[BW-1-W -: W], g[ID_W:1], g[0],
                 exp_q[i][BW-1 -: W], exp_q[i][BW-1-W -: W], exp_q[i][ID_W:1], exp_q[i][0]);
      end
    end
  endtask

  task automatic build_test1_exp();
    exp_q.delete();
    for (int y = 1; y <= 4; y++)
      for (int x = 3; x <= 6; x++)
        exp_q.push_back(beat(x, y, 1, (x == 6 && y == 4)));
  endtask

  // Tests
  task automatic test_reset();
    vec++;
    if ({out_valid, out_last, done, busy} !== 4'b0000) begin
      errs++;
      $display("FAIL reset flags: got %b expected 0000", {out_valid, out_last, done, busy});
    end
    vec++;
    if ({out_x, out_y, out_id} !== '0) begin
      errs++;
      $display("FAIL reset data: got x=%0d y=%0d id=%0d expected 0", out_x, out_y, out_id);
    end
    vec++;
    if (in_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic_scan();
    build_test1_exp();
    send_claim(1, 3, 1, 4, 4);
    collect(100, 0);
    compare_beats("basic");
    vec++;
    if (first_cyc !== acc_cyc + 1) begin
      errs++;
      $display("FAIL basic first beat cycle: got %0d expected %0d", first_cyc, acc_cyc + 1);
    end
    vec++;
    if (last_cyc !== acc_cyc + 16) begin
      errs++;
      $display("FAIL basic last beat cycle: got %0d expected %0d", last_cyc, acc_cyc + 16);
    end
    vec++;
    if (done_cyc !== acc_cyc + 17) begin
      errs++;
      $display("FAIL basic done cycle: got %0d expected %0d", done_cyc, acc_cyc + 17);
    end
  endtask

  task automatic test_zero_area();
    send_claim(5, 2, 2, 0, 5);
    vec++;
    if ({done, out_valid, in_ready, busy} !== 4'b1010) begin
      errs++;
      $display("FAIL zero_area done cycle: got done/valid/ready/busy=%b expected 1010",
               {done, out_valid, in_ready, busy});
    end
    tick();
    vec++;
    if ({done, out_valid} !== 2'b00) begin
      errs++;
      $display("FAIL zero_area after: got done/valid=%b expected 00", {done, out_valid});
    end
    exp_q.delete();
    exp_q.push_back(beat(7, 9, 6, 1'b1));
    send_claim(6, 7, 9, 1, 1);
    collect(20, 0);
    compare_beats("one_by_one");
    vec++;
    if (done_cyc !== acc_cyc + 2) begin
      errs++;
      $display("FAIL one_by_one done cycle: got %0d expected %0d", done_cyc, acc_cyc + 2);
    end
  endtask

  task automatic test_backpressure();
    build_test1_exp();
    bp_at  = 5;
    bp_len = 3;
    send_claim(1, 3, 1, 4, 4);
    collect(100, 0);
    bp_len = 0;
    compare_beats("backpressure");
    vec++;
    if (held_q.size() !== 3) begin
      errs++;
      $display("FAIL bp held cycles: got %0d expected 3", held_q.size());
    end
    for (int i = 0; i < held_q.size(); i++) begin
      vec++;
      if (held_q[i] !== beat(4, 2, 1, 1'b0)) begin
        errs++;
        $display("FAIL bp held beat %0d: got %h expected %h", i, held_q[i], beat(4, 2, 1, 1'b0));
      end
    end
    vec++;
    if (done_cyc !== acc_cyc + 20) begin
      errs++;
      $display("FAIL bp done cycle: got %0d expected %0d", done_cyc, acc_cyc + 20);
    end
  endtask

  task automatic test_edge_of_fabric();
    exp_q.delete();
`ifdef CLAIM_RASTER_CLIP_EN
    exp_q.push_back(beat(998, 0, 7, 1'b0));
    exp_q.push_back(beat(999, 0, 7, 1'b0));
`else
    exp_q.push_back(beat(998, 0, 7, 1'b0));
    exp_q.push_back(beat(999, 0, 7, 1'b0));
    exp_q.push_back(beat(1000, 0, 7, 1'b0));
    exp_q.push_back(beat(1001, 0, 7, 1'b1));
`endif
    send_claim(7, 998, 0, 4, 1);
    collect(50, 0);
    compare_beats("edge");
    vec++;
    if (done_cyc !== acc_cyc + 5) begin
      errs++;
      $display("FAIL edge done cycle: got %0d expected %0d", done_cyc, acc_cyc + 5);
    end
`ifndef CLAIM_RASTER_CLIP_EN
    exp_q.delete();
    exp_q.push_back(beat(1022, 0, 8, 1'b0));
    exp_q.push_back(beat(1023, 0, 8, 1'b0));
    exp_q.push_back(beat(0, 0, 8, 1'b0));
    exp_q.push_back(beat(1, 0, 8, 1'b1));
    send_claim(8, 1022, 0, 4, 1);
    collect(50, 0);
    compare_beats("wrap");
`endif
  endtask

  task automatic test_reset_mid_scan();
    send_claim(1, 3, 1, 4, 4);
    collect(100, 5);
    vec++;
    if (got_q.size() !== 5) begin
      errs++;
      $display("FAIL midreset beats before reset: got %0d expected 5", got_q.size());
    end
    rst_n = 1'b0;
    #1;
    vec++;
    if ({out_valid, busy, done, in_ready} !== 4'b0001) begin
      errs++;
      $display("FAIL midreset async: got valid/busy/done/ready=%b expected 0001",
               {out_valid, busy, done, in_ready});
    end
    tick();
    tick();
    vec++;
    if ({out_valid, done} !== 2'b00) begin
      errs++;
      $display("FAIL midreset held: got valid/done=%b expected 00", {out_valid, done});
    end
    rst_n = 1'b1;
    tick();
    exp_q.delete();
    exp_q.push_back(beat(0, 0, 2, 1'b0));
    exp_q.push_back(beat(1, 0, 2, 1'b1));
    send_claim(2, 0, 0, 2, 1);
    collect(20, 0);
    compare_beats("after_reset");
    vec++;
    if (done_cyc !== acc_cyc + 3) begin
      errs++;
      $display("FAIL after_reset done cycle: got %0d expected %0d", done_cyc, acc_cyc + 3);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] exp_b[3];
    exp_b[1] = beat(1, 1, 3, 1'b0);
    exp_b[2] = beat(2, 1, 3, 1'b1);
    out_ready = 1'b1;
    send_claim(3, 1, 1, 2, 1);
    // Second claim offered immediately and held until accepted.
    in_valid = 1'b1;
    in_id    = ID_W'(4);
    in_left  = W'(5);
    in_top   = W'(5);
    in_w     = W'(1);
    in_h     = W'(1);
    for (int k = 1; k <= 2; k++) begin
      vec++;
      if ({in_ready, busy, out_valid} !== 3'b011) begin
        errs++;
        $display("FAIL b2b scan cycle %0d: got ready/busy/valid=%b expected 011", k,
                 {in_ready, busy, out_valid});
      end
      vec++;
      if (cur_beat() !== exp_b[k]) begin
        errs++;
        $display("FAIL b2b beat %0d: got %h expected %h", k, cur_beat(), exp_b[k]);
      end
      tick();
    end
    vec++;
    if ({done, in_ready, busy, out_valid} !== 4'b1100) begin
      errs++;
      $display("FAIL b2b done cycle: got done/ready/busy/valid=%b expected 1100",
               {done, in_ready, busy, out_valid});
    end
    tick();
    in_valid = 1'b0;
    vec++;
    if ({out_valid, busy, in_ready, done} !== 4'b1100) begin
      errs++;
      $display("FAIL b2b second first cycle: got valid/busy/ready/done=%b expected 1100",
               {out_valid, busy, in_ready, done});
    end
    vec++;
    if (cur_beat() !== beat(5, 5, 4, 1'b1)) begin
      errs++;
      $display("FAIL b2b second beat: got %h expected %h", cur_beat(), beat(5, 5, 4, 1'b1));
    end
    tick();
    vec++;
    if ({done, out_valid} !== 2'b10) begin
      errs++;
      $display("FAIL b2b second done: got done/valid=%b expected 10", {done, out_valid});
    end
    tick();
  endtask

  initial begin
    in_valid  = 1'b0;
    in_left   = '0;
    in_top    = '0;
    in_w      = '0;
    in_h      = '0;
    in_id     = '0;
    out_ready = 1'b1;
    #1;
    test_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_basic_scan();
    tick();
    test_zero_area();
    tick();
    test_backpressure();
    tick();
    test_edge_of_fabric();
    tick();
    test_reset_mid_scan();
    tick();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/claim_rasterizer.md
# claim_rasterizer

Walks a fabric claim rectangle (left, top, w, h) cell by cell and streams every covered (x, y) coordinate with the claim id. It is the generator counterpart of `overlap`: `overlap` answers whether one point lies in a claim, and this block enumerates every point that does. It sits between the claim parser and the per-cell fabric counter of the day-3 datapath.

## Interface
- `W`, 10, coordinate/size width
- `ID_W`, 11, claim id width
- `FABRIC_SIZE`, 1000, fabric edge length; used only under the clip macro
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  claim offered
- `in_ready`  out  1  claim accepted when `in_valid && in_ready`
- `in_left`, `in_top`  in  W  claim origin
- `in_w`, `in_h`  in  W  claim width and height
- `in_id`  in  ID_W  claim id
- `out_valid`  out  1  cell beat valid
- `out_ready`  in  1  downstream accepts beat
- `out_x`, `out_y`  out  W  cell coordinate
- `out_id`  out  ID_W  id of the claim being scanned
- `out_last`  out  1  beat is the claim's final cell
- `done`  out  1  one-cycle pulse: claim scan finished
- `busy`  out  1  state is SCAN

## Operation
- States: IDLE and SCAN.
- `in_ready` is 1 in IDLE and 0 in SCAN.
- IDLE, on accept with `in_w==0` or `in_h==0`:
  - No beats are emitted and the state stays IDLE.
  - `done` pulses in the next cycle.
- IDLE, on accept with nonzero size:
  - The block latches left, top, w, h and id.
  - Offsets `ox=0`, `oy=0`; the state goes to SCAN.
- SCAN emits the current cell:
  - `out_x=left+ox`, `out_y=top+oy`, both truncated to W bits.
  - `out_last=(ox==w-1 && oy==h-1)`.
- Advance happens on `out_valid && out_ready`:
  - Order is row-major with x innermost.
  - If `ox==w-1`, then `ox` clears and `oy` increments; otherwise `ox` increments.
  - Advancing from the final cell returns the state to IDLE and pulses `done`.
- While `out_ready` is 0, `out_x`, `out_y`, `out_id` and `out_last` hold stable. No beat is dropped or duplicated.
- Offsets are W-bit counters compared against w-1 and h-1, so no `left+w` sum is needed for termination.
- Reset values:
  - `out_valid`, `out_last`, `done` and `busy` are 0.
  - `out_x`, `out_y` and `out_id` are 0.
  - `in_ready` is 1 and the state is IDLE.
- Reset asserted mid-scan aborts the claim immediately. No `done` pulse is produced.

## Timing
- All outputs are registered, except `in_ready`, which decodes the state register.
- Claim accepted in cycle N gives the first `out_valid` in cycle N+1.
- With `out_ready` held at 1, beats are issued in cycles N+1 through N+w·h.
- The final handshake is in cycle N+w·h. In cycle N+w·h+1:
  - `done=1`, `busy=0`, `in_ready=1`.
  - A new claim may be accepted in that same cycle.
- Sustained throughput: w·h+1 cycles per claim.
- A zero-area claim accepted in cycle N gives `done` in cycle N+1. `in_ready` stays 1 throughout.
- `in_valid` asserted during SCAN is not accepted. Upstream holds the claim until `in_ready` is 1.

## Configuration
- Macro: `CLAIM_RASTER_CLIP_EN`.
- Undefined: coordinates wrap modulo 2^W, and all w·h cells are emitted.
- Defined:
  - Each coordinate is formed as a W+1-bit sum.
  - A cell with x ≥ `FABRIC_SIZE` or y ≥ `FABRIC_SIZE` is suppressed: `out_valid` is 0 for that cycle and the offsets advance without a handshake.
  - `out_last` appears only on an emitted beat. If the geometric final cell is clipped, no beat carries `out_last`.
  - `done` still pulses one cycle after the final cell is processed, whether emitted or clipped.

## Test plan
1. Basic scan. Drive claim id=1, left=3, top=1, w=4, h=4 with `out_ready=1`.
   - Expect 16 beats: (3,1), (4,1), (5,1), (6,1), (3,2), … ending at (6,4) with `out_last`.
   - Cell (4,4) is present and (4,5) is absent.
   - `done` pulses exactly one cycle after the final beat.
2. Zero area. Drive w=0, h=5.
   - Expect no beats and `done` in the cycle after acceptance.
   - A 1×1 claim at (7,9) then yields a single beat (7,9) with `out_last=1`.
3. Backpressure. In the test-1 claim, drop `out_ready` for 3 cycles at beat 6, which is (4,2).
   - (4,2) is held for all 3 cycles and the sequence resumes without loss or duplication.
4. Edge of fabric. Drive left=998, w=4, top=0, h=1.
   - Macro undefined: beats are x=998, 999, 1000, 1001 with `out_last` on 1001.
   - Macro defined: beats are 998 and 999 only, with no `out_last`, and `done` after 4 scan cycles.
   - Also drive left=1022, w=4 with the macro undefined: x=1022, 1023, 0, 1.
5. Reset mid-scan. Pull `rst_n` low after beat 5 of test 1.
   - `out_valid`, `busy` and `done` go to 0 asynchronously, and `in_ready` goes to 1.
   - After release, claim id=2 at (0,0), 2×1 yields (0,0) then (1,0).
6. Back-to-back claims. Hold `in_valid` high with a second claim during SCAN.
   - `in_ready` stays 0 until the `done` cycle.
   - The second claim is accepted in the `done` cycle, and its first beat follows one cycle later.
